// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bundle.
// ID-side fields in, EX-side registered fields and hazard controls out.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    logic              id_valid;
    logic              id_ALUSrc;
    logic              id_MemtoReg;
    logic              id_RegWrite;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_Branch;
    logic [1:0]        id_ALUOp;
    logic [1:0]        id_MUX_final;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic              ex_flush;

    logic              ex_valid;
    logic              ex_ALUSrc;
    logic              ex_MemtoReg;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_Branch;
    logic [1:0]        ex_ALUOp;
    logic [1:0]        ex_MUX_final;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;
    logic              pc_write;
    logic              ifid_write;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
               id_MUX_final, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
               ex_flush,
        input  ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
               ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
               ex_MUX_final, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
               pc_write, ifid_write, bubble_cnt
    );

    modport slave (
        input  id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_ALUOp,
               id_MUX_final, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7,
               ex_flush,
        output ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
               ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp,
               ex_MUX_final, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
               pc_write, ifid_write, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubbles.
// Counts inserted bubbles in a saturating counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    logic load_use;
    logic bubble;
    logic kill;
    logic rs_hit;

    assign rs_hit   = (bus.ex_rd == bus.id_rs1)
                    | (bus.ex_rd == bus.id_rs2);
    assign load_use = bus.ex_valid & bus.ex_MemRead
                    & (bus.ex_rd != 5'd0)
                    & bus.id_valid & rs_hit;
    assign bubble   = bus.ex_flush | load_use;
    assign kill     = bubble | ~bus.id_valid;

    assign bus.pc_write   = ~load_use & ~bus.ex_flush;
    assign bus.ifid_write = ~load_use & ~bus.ex_flush;

    // Control fields: zeroed on a bubble or an empty ID slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_RegWrite  <= 1'b0;
            bus.ex_MemRead   <= 1'b0;
            bus.ex_MemWrite  <= 1'b0;
            bus.ex_Branch    <= 1'b0;
            bus.ex_ALUOp     <= 2'b00;
            bus.ex_MUX_final <= 2'b00;
        end else if (kill) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_RegWrite  <= 1'b0;
            bus.ex_MemRead   <= 1'b0;
            bus.ex_MemWrite  <= 1'b0;
            bus.ex_Branch    <= 1'b0;
            bus.ex_ALUOp     <= 2'b00;
            bus.ex_MUX_final <= 2'b00;
        end else begin
            bus.ex_valid     <= 1'b1;
            bus.ex_RegWrite  <= bus.id_RegWrite;
            bus.ex_MemRead   <= bus.id_MemRead;
            bus.ex_MemWrite  <= bus.id_MemWrite;
            bus.ex_Branch    <= bus.id_Branch;
            bus.ex_ALUOp     <= bus.id_ALUOp;
            bus.ex_MUX_final <= bus.id_MUX_final;
        end
    end

    // Data and index fields: always follow ID, harmless under a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ex_ALUSrc   <= 1'b0;
            bus.ex_MemtoReg <= 1'b0;
            bus.ex_pc       <= '0;
            bus.ex_rd1      <= '0;
            bus.ex_rd2      <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rs1      <= 5'd0;
            bus.ex_rs2      <= 5'd0;
            bus.ex_rd       <= 5'd0;
            bus.ex_funct3   <= 3'd0;
            bus.ex_funct7   <= 7'd0;
        end else begin
            bus.ex_ALUSrc   <= bus.id_ALUSrc;
            bus.ex_MemtoReg <= bus.id_MemtoReg;
            bus.ex_pc       <= bus.id_pc;
            bus.ex_rd1      <= bus.id_rd1;
            bus.ex_rd2      <= bus.id_rd2;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_rs1      <= bus.id_rs1;
            bus.ex_rs2      <= bus.id_rs2;
            bus.ex_rd       <= bus.id_rd;
            bus.ex_funct3   <= bus.id_funct3;
            bus.ex_funct7   <= bus.id_funct7;
        end
    end

    // Bubble counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.bubble_cnt <= '0;
        end else if (bubble && (bus.bubble_cnt != {CNT_W{1'b1}})) begin
            bus.bubble_cnt <= bus.bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Hazard, flush, saturation and async reset scenarios.
module tb_id_ex_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    id_ex_stage_if #(.DATA_W(32), .CNT_W(16)) bus ();

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        bus.id_valid     = 1'b0;
        bus.id_ALUSrc    = 1'b0;
        bus.id_MemtoReg  = 1'b0;
        bus.id_RegWrite  = 1'b0;
        bus.id_MemRead   = 1'b0;
        bus.id_MemWrite  = 1'b0;
        bus.id_Branch    = 1'b0;
        bus.id_ALUOp     = 2'b00;
        bus.id_MUX_final = 2'b00;
        bus.id_pc        = '0;
        bus.id_rd1       = '0;
        bus.id_rd2       = '0;
        bus.id_imm       = '0;
        bus.id_rs1       = 5'd0;
        bus.id_rs2       = 5'd0;
        bus.id_rd        = 5'd0;
        bus.id_funct3    = 3'd0;
        bus.id_funct7    = 7'd0;
    endtask

    task automatic set_add(input logic [4:0] rd,
                           input logic [4:0] rs1,
                           input logic [4:0] rs2);
        clr_id();
        bus.id_valid    = 1'b1;
        bus.id_RegWrite = 1'b1;
        bus.id_ALUOp    = 2'b10;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
    endtask

    task automatic set_lw(input logic [4:0] rd,
                          input logic [4:0] rs1);
        clr_id();
        bus.id_valid     = 1'b1;
        bus.id_ALUSrc    = 1'b1;
        bus.id_MemtoReg  = 1'b1;
        bus.id_RegWrite  = 1'b1;
        bus.id_MemRead   = 1'b1;
        bus.id_MUX_final = 2'b01;
        bus.id_rd        = rd;
        bus.id_rs1       = rs1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.ex_flush = 1'b0;
        clr_id();
        #3;
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("rst_pcw", 32'(bus.pc_write), 32'd1);
        chk("rst_ifidw", 32'(bus.ifid_write), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // add x3,x1,x2
        set_add(5'd3, 5'd1, 5'd2);
        bus.id_pc  = 32'h100;
        bus.id_rd1 = 32'h11;
        tick();
        chk("add_rd", 32'(bus.ex_rd), 32'd3);
        chk("add_rw", 32'(bus.ex_RegWrite), 32'd1);
        chk("add_aluop", 32'(bus.ex_ALUOp), 32'd2);
        chk("add_valid", 32'(bus.ex_valid), 32'd1);
        chk("add_pc", bus.ex_pc, 32'h100);
        chk("add_rd1", bus.ex_rd1, 32'h11);

        // invalid ID slot with control bits set
        set_add(5'd4, 5'd1, 5'd2);
        bus.id_valid = 1'b0;
        tick();
        chk("inv_valid", 32'(bus.ex_valid), 32'd0);
        chk("inv_rw", 32'(bus.ex_RegWrite), 32'd0);
        chk("inv_cnt", 32'(bus.bubble_cnt), 32'd0);

        // lw x5 then add x6,x5,x7
        set_lw(5'd5, 5'd1);
        tick();
        set_add(5'd6, 5'd5, 5'd7);
        #1;
        chk("lu_pcw", 32'(bus.pc_write), 32'd0);
        chk("lu_ifidw", 32'(bus.ifid_write), 32'd0);
        tick();
        chk("lu_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_rw", 32'(bus.ex_RegWrite), 32'd0);
        chk("lu_cnt", 32'(bus.bubble_cnt), 32'd1);
        chk("lu_pcw2", 32'(bus.pc_write), 32'd1);
        tick();
        chk("lu_add_rd", 32'(bus.ex_rd), 32'd6);
        chk("lu_add_v", 32'(bus.ex_valid), 32'd1);

        // lw x0 then rs1=0: no stall
        set_lw(5'd0, 5'd1);
        tick();
        set_add(5'd6, 5'd0, 5'd0);
        #1;
        chk("x0_pcw", 32'(bus.pc_write), 32'd1);
        tick();
        chk("x0_cnt", 32'(bus.bubble_cnt), 32'd1);
        chk("x0_valid", 32'(bus.ex_valid), 32'd1);

        // flush with sw in ID
        clr_id();
        bus.id_valid     = 1'b1;
        bus.id_MemWrite  = 1'b1;
        bus.id_MUX_final = 2'b10;
        bus.id_Branch    = 1'b1;
        bus.ex_flush     = 1'b1;
        #1;
        chk("fl_pcw", 32'(bus.pc_write), 32'd0);
        tick();
        chk("fl_mw", 32'(bus.ex_MemWrite), 32'd0);
        chk("fl_valid", 32'(bus.ex_valid), 32'd0);
        chk("fl_mux", 32'(bus.ex_MUX_final), 32'd0);
        chk("fl_br", 32'(bus.ex_Branch), 32'd0);
        chk("fl_cnt", 32'(bus.bubble_cnt), 32'd2);
        bus.ex_flush = 1'b0;

        // flush and load-use together
        set_lw(5'd5, 5'd1);
        tick();
        set_add(5'd6, 5'd5, 5'd7);
        bus.ex_flush = 1'b1;
        #1;
        chk("both_ifidw", 32'(bus.ifid_write), 32'd0);
        tick();
        chk("both_cnt", 32'(bus.bubble_cnt), 32'd3);
        chk("both_valid", 32'(bus.ex_valid), 32'd0);
        bus.ex_flush = 1'b0;

        // reset in the middle of a stall
        set_lw(5'd5, 5'd1);
        tick();
        set_add(5'd6, 5'd5, 5'd7);
        #1;
        chk("rs_pcw0", 32'(bus.pc_write), 32'd0);
        reset = 1'b0;
        #1;
        chk("rs_valid", 32'(bus.ex_valid), 32'd0);
        chk("rs_pcw1", 32'(bus.pc_write), 32'd1);
        chk("rs_cnt", 32'(bus.bubble_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rs_cap_rd", 32'(bus.ex_rd), 32'd6);
        chk("rs_cap_v", 32'(bus.ex_valid), 32'd1);
        chk("rs_cnt2", 32'(bus.bubble_cnt), 32'd0);

        // saturate the counter
        set_add(5'd9, 5'd1, 5'd2);
        bus.id_pc    = 32'h200;
        bus.ex_flush = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(bus.bubble_cnt), 32'h0000FFFF);
        tick();
        chk("sat_hold", 32'(bus.bubble_cnt), 32'h0000FFFF);
        chk("sat_rd", 32'(bus.ex_rd), 32'd9);

        // async reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        chk("ar_cnt", 32'(bus.bubble_cnt), 32'd0);
        chk("ar_rd", 32'(bus.ex_rd), 32'd0);
        chk("ar_pc", bus.ex_pc, 32'd0);
        chk("ar_valid", 32'(bus.ex_valid), 32'd0);
        bus.ex_flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
